// File: rtl/prog_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// prog_mem_arbiter_if
// Bundles every non-clock/non-reset signal of prog_mem_arbiter: the mode
// request, the loader stream, the CPU fetch and debug read channels, the
// single RAM port and the load status outputs.
//
//   slave  : the arbiter side (drives grants, RAM port, read returns, status)
//   master : the environment side (loader, CPU, debug, RAM, mode control)
//
// Signal summary (directions as seen by the slave):
//   mode                     in   0 = LOAD, 1 = RUN (level)
//   ld_valid/ld_data         in   loader word stream
//   ld_ready                 out  loader word accepted when ld_valid & ld_ready
//   ld_clear                 in   pulse: rewind write pointer and count
//   fetch_req/fetch_addr     in   CPU fetch request
//   fetch_gnt                out  fetch issued to RAM this cycle
//   fetch_valid/fetch_data   out  fetch return (data held between pulses)
//   dbg_req/dbg_addr         in   debug read request
//   dbg_gnt                  out  debug read issued this cycle
//   dbg_valid/dbg_data       out  debug return (data held between pulses)
//   ram_en/ram_we/ram_addr/ram_wdata  out  RAM port
//   ram_rdata                in   RAM read data, one cycle after a read
//   run_mode                 out  arbiter is in RUN
//   wr_ptr                   out  next load address
//   wr_count                 out  words loaded since clear (saturating)
//   load_full                out  wr_count == 2**ADDR_W
// ----------------------------------------------------------------------------
interface prog_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);

  logic              mode;

  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              ld_clear;

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_gnt;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;

  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_gnt;
  logic              dbg_valid;
  logic [DATA_W-1:0] dbg_data;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              run_mode;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   wr_count;
  logic              load_full;

  modport slave (
    input  mode,
    input  ld_valid, ld_data, ld_clear,
    output ld_ready,
    input  fetch_req, fetch_addr,
    output fetch_gnt, fetch_valid, fetch_data,
    input  dbg_req, dbg_addr,
    output dbg_gnt, dbg_valid, dbg_data,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output run_mode, wr_ptr, wr_count, load_full
  );

  modport master (
    output mode,
    output ld_valid, ld_data, ld_clear,
    input  ld_ready,
    output fetch_req, fetch_addr,
    input  fetch_gnt, fetch_valid, fetch_data,
    output dbg_req, dbg_addr,
    input  dbg_gnt, dbg_valid, dbg_data,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  run_mode, wr_ptr, wr_count, load_full
  );

endinterface

// File: rtl/prog_mem_arbiter.sv
// ----------------------------------------------------------------------------
// prog_mem_arbiter
// Arbiter and sequencer for the single-port program RAM shared by the UART
// word loader, the CPU fetch unit and a debug readback port.
//
//   - Owns the load write pointer / word count and the LOAD/RUN mode FSM.
//   - A mode change passes through a one-cycle drain state with no grants so
//     that any read in flight returns before the other mode starts.
//   - LOAD: loader has priority over debug; fetch is never granted.
//     RUN : fetch has priority over debug; the loader is never granted.
//   - A debug request that has waited STARVE_LIMIT cycles is forced through
//     for one cycle ahead of loader/fetch.
//   - Reads have one cycle of latency; a one-bit owner tag routes the
//     returning word to fetch_* or dbg_*. Returned words are held until the
//     next return to the same requester.
//
// Ports:
//   clk    in  system clock, all state on the rising edge
//   reset  in  asynchronous, active-low reset
//   bus    prog_mem_arbiter_if.slave (see interface for the signal list)
//
// ADDR_W/DATA_W must match the parameters of the connected interface.
// ----------------------------------------------------------------------------
module prog_mem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 15   // 1..255
) (
  input  logic              clk,
  input  logic              reset,
  prog_mem_arbiter_if.slave bus
);

  // FSM encoding
  localparam logic [1:0] ST_LOAD    = 2'd0;
  localparam logic [1:0] ST_DRAIN_R = 2'd1;  // LOAD -> RUN
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_DRAIN_L = 2'd3;  // RUN -> LOAD

  // wr_count value when every RAM word has been written
  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [7:0]      STARVE_MAX = 8'(STARVE_LIMIT);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]        state_q,      state_d;
  logic [ADDR_W-1:0] wr_ptr_q,     wr_ptr_d;
  logic [ADDR_W:0]   wr_count_q,   wr_count_d;
  logic [7:0]        starve_q,     starve_d;
  logic              rd_pend_q,    rd_pend_d;     // read issued last cycle
  logic              rd_dbg_q,     rd_dbg_d;      // owner tag: 1 = debug
  logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
  logic [DATA_W-1:0] dbg_data_q,   dbg_data_d;

  // --------------------------------------------------------------------------
  // Grant logic
  // --------------------------------------------------------------------------
  logic in_load;
  logic in_run;
  logic grant_window;
  logic load_full;
  logic force_dbg;
  logic ld_ready;
  logic ld_wr;
  logic fetch_gnt;
  logic dbg_gnt;

  assign in_load = (state_q == ST_LOAD);
  assign in_run  = (state_q == ST_RUN);

  // NOTE: reset is folded into the grant window so every combinational output
  // (ld_ready, grants, RAM strobe) is already 0 while reset is held low,
  // not only after the next clock edge.
  assign grant_window = reset & (in_load | in_run);

  assign load_full = (wr_count_q == FULL_COUNT);
  assign force_dbg = grant_window & bus.dbg_req & (starve_q == STARVE_MAX);

  assign ld_ready  = grant_window & in_load & ~load_full & ~bus.ld_clear & ~force_dbg;
  assign ld_wr     = ld_ready & bus.ld_valid;
  assign fetch_gnt = grant_window & in_run & bus.fetch_req & ~force_dbg;
  // Debug takes whatever slot the higher-priority requester leaves free; when
  // force_dbg is set both ld_wr and fetch_gnt are already suppressed.
  assign dbg_gnt   = grant_window & bus.dbg_req & ~(ld_wr | fetch_gnt);

  // --------------------------------------------------------------------------
  // RAM port
  // --------------------------------------------------------------------------
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (ld_wr) begin
      ram_we    = 1'b1;
      ram_addr  = wr_ptr_q;
      ram_wdata = bus.ld_data;
    end else if (fetch_gnt) begin
      ram_addr  = bus.fetch_addr;
    end else if (dbg_gnt) begin
      ram_addr  = bus.dbg_addr;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:    if (bus.mode)  state_d = ST_DRAIN_R;
      ST_DRAIN_R:                state_d = ST_RUN;
      ST_RUN:     if (!bus.mode) state_d = ST_DRAIN_L;
      ST_DRAIN_L:                state_d = ST_LOAD;
      default:                   state_d = ST_LOAD;
    endcase
  end

  // Load pointer and count; a clear wins over (and blocks) a write.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    wr_count_d = wr_count_q;
    if (bus.ld_clear) begin
      wr_ptr_d   = '0;
      wr_count_d = '0;
    end else if (ld_wr) begin
      wr_ptr_d = wr_ptr_q + 1'b1;   // wraps mod 2**ADDR_W
      if (wr_count_q != FULL_COUNT) begin
        wr_count_d = wr_count_q + 1'b1;
      end
    end
  end

  // Starvation counter: counts consecutive cycles a debug request is refused.
  // It parks at STARVE_MAX (e.g. across a drain cycle) until the grant lands.
  always_comb begin
    starve_d = starve_q;
    if (!bus.dbg_req || dbg_gnt) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + 8'd1;
    end
  end

  // Read return path
  logic fetch_valid;
  logic dbg_valid;

  assign rd_pend_d   = fetch_gnt | dbg_gnt;
  assign rd_dbg_d    = dbg_gnt;
  assign fetch_valid = rd_pend_q & ~rd_dbg_q;
  assign dbg_valid   = rd_pend_q &  rd_dbg_q;

  // The returning word is presented in the same cycle as its valid pulse and
  // captured so the output holds it until the next return.
  assign fetch_data_d = fetch_valid ? bus.ram_rdata : fetch_data_q;
  assign dbg_data_d   = dbg_valid   ? bus.ram_rdata : dbg_data_q;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_LOAD;
      wr_ptr_q     <= '0;
      wr_count_q   <= '0;
      starve_q     <= '0;
      rd_pend_q    <= 1'b0;
      rd_dbg_q     <= 1'b0;
      fetch_data_q <= '0;
      dbg_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_count_q   <= wr_count_d;
      starve_q     <= starve_d;
      rd_pend_q    <= rd_pend_d;
      rd_dbg_q     <= rd_dbg_d;
      fetch_data_q <= fetch_data_d;
      dbg_data_q   <= dbg_data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.ld_ready    = ld_ready;
  assign bus.fetch_gnt   = fetch_gnt;
  assign bus.fetch_valid = fetch_valid;
  assign bus.fetch_data  = fetch_data_d;
  assign bus.dbg_gnt     = dbg_gnt;
  assign bus.dbg_valid   = dbg_valid;
  assign bus.dbg_data    = dbg_data_d;
  assign bus.ram_en      = ld_wr | fetch_gnt | dbg_gnt;
  assign bus.ram_we      = ram_we;
  assign bus.ram_addr    = ram_addr;
  assign bus.ram_wdata   = ram_wdata;
  assign bus.run_mode    = in_run;
  assign bus.wr_ptr      = wr_ptr_q;
  assign bus.wr_count    = wr_count_q;
  assign bus.load_full   = load_full;

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_prog_mem_arbiter
// Self-checking bench for prog_mem_arbiter with STARVE_LIMIT = 4. A 256x16
// synchronous RAM sits on the DUT's RAM port; a separate shadow of the loaded
// contents plus a small rule-level model (write count/pointer, debug wait
// count, one pending read) predicts grants and returned data.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ----------------------------------------------------------------------------
module tb_prog_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  prog_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  prog_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Physical RAM behind the DUT port
  logic [DW-1:0] ram_mem [256];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata <= ram_mem[bus.ram_addr];
    end
  end

  // Reference state
  logic [DW-1:0] model_mem [256];
  int            m_wc = 0;          // words loaded since clear
  int            m_wp = 0;          // next load address
  logic [DW-1:0] m_fetch_data = '0; // last fetched word
  logic [DW-1:0] m_dbg_data   = '0; // last debug word

  int vectors     = 0;
  int miscompares = 0;

  task automatic drive_idle();
    bus.mode       = 1'b0;
    bus.ld_valid   = 1'b0;
    bus.ld_data    = '0;
    bus.ld_clear   = 1'b0;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.dbg_req    = 1'b0;
    bus.dbg_addr   = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    logic [63:0] flags;
    // reset is held low on entry; requests must not leak through
    bus.ld_valid  = 1'b1;
    bus.fetch_req = 1'b1;
    bus.dbg_req   = 1'b1;
    @(negedge clk);
    flags = 64'({bus.ld_ready, bus.fetch_gnt, bus.dbg_gnt, bus.ram_en, bus.ram_we,
                 bus.run_mode, bus.load_full, bus.fetch_valid, bus.dbg_valid});
    vectors++;
    if (flags !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_flags got %h want 0", flags);
    end
    vectors++;
    if ({bus.wr_ptr, bus.wr_count, bus.fetch_data, bus.dbg_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_regs got %h want 0",
               {bus.wr_ptr, bus.wr_count, bus.fetch_data, bus.dbg_data});
    end
    drive_idle();
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.ld_ready, bus.run_mode} !== 2'b10) begin
      miscompares++;
      $display("FAIL post_reset ld_ready/run_mode got %b want 10", {bus.ld_ready, bus.run_mode});
    end
    next_cycle();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_load_stream();
    logic [DW-1:0] words [3];
    words[0] = 16'h1111;
    words[1] = 16'h2222;
    words[2] = 16'h3333;
    for (int i = 0; i < 3; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = words[i];
      @(negedge clk);
      vectors++;
      if ({bus.ld_ready, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata} !==
          {3'b111, 8'(i), words[i]}) begin
        miscompares++;
        $display("FAIL load_write[%0d] got %h want %h", i,
                 {bus.ld_ready, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata},
                 {3'b111, 8'(i), words[i]});
      end
      model_mem[i] = words[i];
      next_cycle();
    end
    m_wc = 3;
    m_wp = 3;
    bus.ld_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.wr_ptr, bus.wr_count, bus.ld_ready} !== {8'd3, 9'd3, 1'b1}) begin
      miscompares++;
      $display("FAIL load_status got ptr=%0d cnt=%0d rdy=%b want 3 3 1",
               bus.wr_ptr, bus.wr_count, bus.ld_ready);
    end
    next_cycle();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_fill_and_clear();
    for (int i = 3; i < 256; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 16'($urandom);
      @(negedge clk);
      vectors++;
      if ({bus.ld_ready, bus.ram_we, bus.ram_addr, bus.load_full} !== {2'b11, 8'(i), 1'b0}) begin
        miscompares++;
        $display("FAIL fill_write[%0d] rdy=%b we=%b addr=%0d full=%b", i,
                 bus.ld_ready, bus.ram_we, bus.ram_addr, bus.load_full);
      end
      model_mem[i] = bus.ld_data;
      next_cycle();
    end
    // 257th word must be refused
    bus.ld_data = 16'hDEAD;
    @(negedge clk);
    vectors++;
    if ({bus.load_full, bus.wr_ptr, bus.wr_count, bus.ld_ready, bus.ram_en} !==
        {1'b1, 8'd0, 9'd256, 2'b00}) begin
      miscompares++;
      $display("FAIL full_state full=%b ptr=%0d cnt=%0d rdy=%b en=%b want 1 0 256 0 0",
               bus.load_full, bus.wr_ptr, bus.wr_count, bus.ld_ready, bus.ram_en);
    end
    next_cycle();
    bus.ld_clear = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.ld_ready, bus.ram_en} !== 2'b00) begin
      miscompares++;
      $display("FAIL clear_blocks got %b want 00", {bus.ld_ready, bus.ram_en});
    end
    next_cycle();
    bus.ld_clear = 1'b0;
    bus.ld_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.wr_count, bus.wr_ptr, bus.load_full, bus.ld_ready} !== {9'd0, 8'd0, 2'b01}) begin
      miscompares++;
      $display("FAIL after_clear cnt=%0d ptr=%0d full=%b rdy=%b want 0 0 0 1",
               bus.wr_count, bus.wr_ptr, bus.load_full, bus.ld_ready);
    end
    m_wc = 0;
    m_wp = 0;
    next_cycle();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_mode_switch();
    bus.mode     = 1'b1;
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 8'd1;
    @(negedge clk);
    vectors++;
    if ({bus.dbg_gnt, bus.ram_en, bus.ram_we, bus.ram_addr, bus.run_mode} !== {3'b110, 8'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL switch_dbg_gnt got %h want %h",
               {bus.dbg_gnt, bus.ram_en, bus.ram_we, bus.ram_addr, bus.run_mode}, {3'b110, 8'd1, 1'b0});
    end
    next_cycle();
    // drain cycle: read returns, fetch must wait
    bus.dbg_req    = 1'b0;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 8'd2;
    m_dbg_data     = model_mem[1];
    @(negedge clk);
    vectors++;
    if ({bus.dbg_valid, bus.dbg_data, bus.run_mode, bus.ram_en, bus.fetch_gnt} !==
        {1'b1, m_dbg_data, 3'b000}) begin
      miscompares++;
      $display("FAIL drain_cycle got %h want %h",
               {bus.dbg_valid, bus.dbg_data, bus.run_mode, bus.ram_en, bus.fetch_gnt},
               {1'b1, m_dbg_data, 3'b000});
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({bus.run_mode, bus.fetch_gnt, bus.ram_addr, bus.dbg_valid} !== {2'b11, 8'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL run_fetch got %h want %h",
               {bus.run_mode, bus.fetch_gnt, bus.ram_addr, bus.dbg_valid}, {2'b11, 8'd2, 1'b0});
    end
    next_cycle();
    bus.fetch_req = 1'b0;
    m_fetch_data  = model_mem[2];
    @(negedge clk);
    vectors++;
    if ({bus.fetch_valid, bus.fetch_data} !== {1'b1, 16'h3333}) begin
      miscompares++;
      $display("FAIL fetch_return got %b/%h want 1/3333", bus.fetch_valid, bus.fetch_data);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({bus.fetch_valid, bus.fetch_data, bus.ram_en} !== {1'b0, 16'h3333, 1'b0}) begin
      miscompares++;
      $display("FAIL fetch_hold got %b/%h/%b want 0/3333/0", bus.fetch_valid, bus.fetch_data, bus.ram_en);
    end
    next_cycle();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_starve();
    bit prev_valid = 1'b0;
    bit prev_dbg   = 1'b0;
    bit exp_dbg;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 8'd0;
    bus.dbg_req    = 1'b1;
    bus.dbg_addr   = 8'd1;
    for (int c = 1; c <= 11; c++) begin
      if (c == 11) begin
        bus.fetch_req = 1'b0;
        bus.dbg_req   = 1'b0;
      end
      exp_dbg = (c <= 10) && (c % 5 == 0);
      @(negedge clk);
      if (c <= 10) begin
        vectors++;
        if ({bus.fetch_gnt, bus.dbg_gnt} !== {~exp_dbg, exp_dbg}) begin
          miscompares++;
          $display("FAIL starve_gnt[%0d] fetch/dbg got %b%b want %b%b", c,
                   bus.fetch_gnt, bus.dbg_gnt, ~exp_dbg, exp_dbg);
        end
      end
      if (prev_valid) begin
        if (prev_dbg) m_dbg_data   = model_mem[1];
        else          m_fetch_data = model_mem[0];
      end
      vectors++;
      if ({bus.fetch_valid, bus.dbg_valid, bus.fetch_data, bus.dbg_data} !==
          {prev_valid & ~prev_dbg, prev_valid & prev_dbg, m_fetch_data, m_dbg_data}) begin
        miscompares++;
        $display("FAIL starve_ret[%0d] got %h want %h", c,
                 {bus.fetch_valid, bus.dbg_valid, bus.fetch_data, bus.dbg_data},
                 {prev_valid & ~prev_dbg, prev_valid & prev_dbg, m_fetch_data, m_dbg_data});
      end
      prev_valid = (c <= 10);
      prev_dbg   = exp_dbg;
      next_cycle();
    end
  endtask

  // --------------------------------------------------------------------------
  // Random traffic in RUN: fetch has priority, debug forced after SL refusals.
  task automatic test_random_run();
    int            waited = 0;
    bit            pend = 1'b0, pend_dbg = 1'b0;
    logic [DW-1:0] pend_data = '0;
    bit            force_d, ef, ed;
    for (int n = 0; n < 301; n++) begin
      bus.fetch_req  = (n < 300) && ($urandom_range(0, 9) < 8);
      bus.dbg_req    = (n < 300) && ($urandom_range(0, 9) < 4);
      bus.fetch_addr = 8'($urandom);
      bus.dbg_addr   = 8'($urandom);
      bus.ld_valid   = 1'($urandom);
      force_d = bus.dbg_req && (waited == SL);
      ef      = bus.fetch_req && !force_d;
      ed      = bus.dbg_req && !ef;
      if (pend) begin
        if (pend_dbg) m_dbg_data   = pend_data;
        else          m_fetch_data = pend_data;
      end
      @(negedge clk);
      vectors++;
      if ({bus.ld_ready, bus.fetch_gnt, bus.dbg_gnt, bus.ram_en, bus.ram_we} !=
          {1'b0, ef, ed, ef | ed, 1'b0}) begin
        miscompares++;
        $display("FAIL run_gnt[%0d] rdy/fg/dg/en/we got %b want %b", n,
                 {bus.ld_ready, bus.fetch_gnt, bus.dbg_gnt, bus.ram_en, bus.ram_we},
                 {1'b0, ef, ed, ef | ed, 1'b0});
      end
      if (ef || ed) begin
        vectors++;
        if (bus.ram_addr !== (ef ? bus.fetch_addr : bus.dbg_addr)) begin
          miscompares++;
          $display("FAIL run_addr[%0d] got %0d want %0d", n, bus.ram_addr,
                   ef ? bus.fetch_addr : bus.dbg_addr);
        end
      end
      vectors++;
      if ({bus.fetch_valid, bus.dbg_valid, bus.fetch_data, bus.dbg_data} !==
          {pend & ~pend_dbg, pend & pend_dbg, m_fetch_data, m_dbg_data}) begin
        miscompares++;
        $display("FAIL run_ret[%0d] got %h want %h", n,
                 {bus.fetch_valid, bus.dbg_valid, bus.fetch_data, bus.dbg_data},
                 {pend & ~pend_dbg, pend & pend_dbg, m_fetch_data, m_dbg_data});
      end
      waited    = (!bus.dbg_req || ed) ? 0 : waited + 1;
      pend      = ef || ed;
      pend_dbg  = ed;
      pend_data = model_mem[ef ? bus.fetch_addr : bus.dbg_addr];
      next_cycle();
    end
    bus.ld_valid = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_load_blocks_fetch();
    bus.mode = 1'b0;   // still RUN this cycle, no requests
    @(negedge clk);
    vectors++;
    if ({bus.run_mode, bus.ram_en} !== 2'b10) begin
      miscompares++;
      $display("FAIL to_load_run got %b want 10", {bus.run_mode, bus.ram_en});
    end
    next_cycle();
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 8'd5;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      vectors++;
      if ({bus.fetch_gnt, bus.fetch_valid, bus.run_mode, bus.ram_en, bus.fetch_data} !==
          {4'b0000, m_fetch_data}) begin
        miscompares++;
        $display("FAIL load_no_fetch[%0d] got %h want %h", c,
                 {bus.fetch_gnt, bus.fetch_valid, bus.run_mode, bus.ram_en, bus.fetch_data},
                 {4'b0000, m_fetch_data});
      end
      next_cycle();
    end
    bus.fetch_req = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Random traffic in LOAD: loader priority, clears, forced debug, readback.
  task automatic test_random_load();
    int            waited = 0;
    bit            pend = 1'b0;
    logic [DW-1:0] pend_data = '0;
    bit            force_d, elr, ew, ed;
    for (int n = 0; n < 241; n++) begin
      bus.ld_valid   = (n < 240) && ($urandom_range(0, 9) < 7);
      bus.ld_data    = 16'($urandom);
      bus.ld_clear   = (n < 240) && ($urandom_range(0, 31) == 0);
      bus.dbg_req    = (n < 240) && ($urandom_range(0, 9) < 3);
      bus.dbg_addr   = 8'($urandom_range(0, 15));
      bus.fetch_req  = 1'($urandom);
      bus.fetch_addr = 8'($urandom);
      force_d = bus.dbg_req && (waited == SL);
      elr     = (m_wc < 256) && !bus.ld_clear && !force_d;
      ew      = elr && bus.ld_valid;
      ed      = bus.dbg_req && !ew;
      if (pend) m_dbg_data = pend_data;
      @(negedge clk);
      vectors++;
      if ({bus.ld_ready, bus.fetch_gnt, bus.dbg_gnt, bus.ram_en, bus.ram_we} !=
          {elr, 1'b0, ed, ew | ed, ew}) begin
        miscompares++;
        $display("FAIL load_gnt[%0d] rdy/fg/dg/en/we got %b want %b", n,
                 {bus.ld_ready, bus.fetch_gnt, bus.dbg_gnt, bus.ram_en, bus.ram_we},
                 {elr, 1'b0, ed, ew | ed, ew});
      end
      if (ew) begin
        vectors++;
        if ({bus.ram_addr, bus.ram_wdata} !== {8'(m_wp), bus.ld_data}) begin
          miscompares++;
          $display("FAIL load_wr[%0d] got %h want %h", n,
                   {bus.ram_addr, bus.ram_wdata}, {8'(m_wp), bus.ld_data});
        end
      end else if (ed) begin
        vectors++;
        if (bus.ram_addr !== bus.dbg_addr) begin
          miscompares++;
          $display("FAIL load_dbg_addr[%0d] got %0d want %0d", n, bus.ram_addr, bus.dbg_addr);
        end
      end
      vectors++;
      if ({bus.wr_ptr, bus.wr_count, bus.load_full, bus.fetch_valid, bus.dbg_valid, bus.dbg_data} !==
          {8'(m_wp), 9'(m_wc), m_wc == 256, 1'b0, pend, m_dbg_data}) begin
        miscompares++;
        $display("FAIL load_state[%0d] got %h want %h", n,
                 {bus.wr_ptr, bus.wr_count, bus.load_full, bus.fetch_valid, bus.dbg_valid, bus.dbg_data},
                 {8'(m_wp), 9'(m_wc), m_wc == 256, 1'b0, pend, m_dbg_data});
      end
      if (bus.ld_clear) begin
        m_wc = 0;
        m_wp = 0;
      end else if (ew) begin
        model_mem[m_wp] = bus.ld_data;
        m_wp = (m_wp + 1) % 256;
        m_wc = m_wc + 1;
      end
      waited    = (!bus.dbg_req || ed) ? 0 : waited + 1;
      pend      = ed;
      pend_data = model_mem[bus.dbg_addr];
      next_cycle();
    end
    drive_idle();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_inflight();
    bus.mode = 1'b1;
    next_cycle();               // LOAD -> DRAIN_R
    next_cycle();               // DRAIN_R -> RUN
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 8'd3;
    @(negedge clk);
    vectors++;
    if ({bus.run_mode, bus.fetch_gnt} !== 2'b11) begin
      miscompares++;
      $display("FAIL rst_pre_gnt got %b want 11", {bus.run_mode, bus.fetch_gnt});
    end
    next_cycle();
    reset = 1'b0;               // read is in flight
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({bus.ld_ready, bus.fetch_gnt, bus.fetch_valid, bus.fetch_data, bus.dbg_gnt,
           bus.dbg_valid, bus.dbg_data, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata,
           bus.run_mode, bus.wr_ptr, bus.wr_count, bus.load_full} !== '0) begin
        miscompares++;
        $display("FAIL rst_outputs[%0d] some output nonzero fv=%b fd=%h en=%b run=%b cnt=%0d",
                 k, bus.fetch_valid, bus.fetch_data, bus.ram_en, bus.run_mode, bus.wr_count);
      end
      @(negedge clk);
    end
    bus.mode = 1'b0;
    next_cycle();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++;
      if ({bus.fetch_valid, bus.fetch_gnt, bus.run_mode, bus.fetch_data, bus.ld_ready} !==
          {3'b000, 16'h0000, 1'b1}) begin
        miscompares++;
        $display("FAIL rst_release[%0d] got %h want %h", c,
                 {bus.fetch_valid, bus.fetch_gnt, bus.run_mode, bus.fetch_data, bus.ld_ready},
                 {3'b000, 16'h0000, 1'b1});
      end
      next_cycle();
    end
    drive_idle();
  endtask

  // --------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i]   = '0;
      model_mem[i] = '0;
    end
    bus.ram_rdata = '0;
    reset = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load_stream();
    test_fill_and_clear();
    test_mode_switch();
    test_starve();
    test_random_run();
    test_load_blocks_fetch();
    test_random_load();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
